// File: rtl/timer_multi.sv
// Multi-channel down-counting timer with a shared prescaler, one-shot/periodic
// modes, forced reload and per-channel write-1-to-clear interrupt flags.
module timer_multi #(
   parameter int NUM_CH      = 4,
   parameter int CNT_WIDTH   = 32,
   parameter int PRESC_WIDTH = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              bus_valid,
   input  logic              bus_we,
   input  logic [7:0]        bus_addr,
   input  logic [31:0]       bus_wdata,
   output logic [31:0]       bus_rdata,
   output logic              bus_ready,
   output logic [NUM_CH-1:0] irq,
   output logic              irq_any
);

   logic                   ready_q;
   logic [31:0]            rdata_q;
   logic [PRESC_WIDTH-1:0] presc_q, presc_d;
   logic [PRESC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
   logic [NUM_CH-1:0]      en_q, en_d;
   logic [NUM_CH-1:0]      mode_q, mode_d;
   logic [NUM_CH-1:0]      ien_q, ien_d;
   logic [NUM_CH-1:0]      flag_q, flag_d;
   logic [CNT_WIDTH-1:0]   load_q [NUM_CH];
   logic [CNT_WIDTH-1:0]   load_d [NUM_CH];
   logic [CNT_WIDTH-1:0]   count_q [NUM_CH];
   logic [CNT_WIDTH-1:0]   count_d [NUM_CH];

   logic              accept;
   logic              wr_en;
   logic              glob_sel;
   logic [1:0]        reg_sel;
   logic              tick;
   logic [NUM_CH-1:0] ch_wr;
   logic [31:0]       rd_data;
   logic              unused_bits;

   // An access is taken on the edge that raises ready; ready then drops, so
   // a held bus_valid cannot be accepted twice back to back.
   assign accept   = bus_valid & ~ready_q;
   assign wr_en    = accept & bus_we;
   assign glob_sel = bus_addr[7];
   assign reg_sel  = bus_addr[3:2];
   assign tick     = (presc_cnt_q == presc_q);

   assign unused_bits = ^{bus_addr[1:0], bus_wdata};

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         ch_wr[i] = wr_en && !glob_sel && (bus_addr[6:4] == 3'(i));
      end
   end

   always_comb begin
      presc_d     = presc_q;
      presc_cnt_d = tick ? '0 : presc_cnt_q + PRESC_WIDTH'(1);
      if (wr_en && glob_sel && bus_addr[6:2] == 5'd0) begin
         presc_d     = bus_wdata[PRESC_WIDTH-1:0];
         presc_cnt_d = '0;
      end

      for (int i = 0; i < NUM_CH; i++) begin
         en_d[i]    = en_q[i];
         mode_d[i]  = mode_q[i];
         ien_d[i]   = ien_q[i];
         flag_d[i]  = flag_q[i];
         load_d[i]  = load_q[i];
         count_d[i] = count_q[i];

         // Clear first so that an expiry on the same edge sets the flag again.
         if (ch_wr[i] && reg_sel == 2'd3 && bus_wdata[0]) begin
            flag_d[i] = 1'b0;
         end

         if (en_q[i] && tick) begin
            if (count_q[i] != '0) begin
               count_d[i] = count_q[i] - CNT_WIDTH'(1);
            end else begin
               flag_d[i] = 1'b1;
               if (mode_q[i]) begin
                  count_d[i] = load_q[i];
               end else begin
                  en_d[i] = 1'b0;
               end
            end
         end

         // A CTRL write overrides whatever the tick did to EN and COUNT.
         if (ch_wr[i] && reg_sel == 2'd0) begin
            en_d[i]   = bus_wdata[0];
            mode_d[i] = bus_wdata[1];
            ien_d[i]  = bus_wdata[2];
            if ((bus_wdata[0] && !en_q[i]) || bus_wdata[3]) begin
               count_d[i] = load_q[i];
            end
         end

         if (ch_wr[i] && reg_sel == 2'd1) begin
            load_d[i] = bus_wdata[CNT_WIDTH-1:0];
         end
      end
   end

   always_comb begin
      rd_data = '0;
      if (glob_sel) begin
         if (bus_addr[6:2] == 5'd0) begin
            rd_data[PRESC_WIDTH-1:0] = presc_q;
         end else if (bus_addr[6:2] == 5'd1) begin
            rd_data[NUM_CH-1:0] = flag_q;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (bus_addr[6:4] == 3'(i)) begin
               case (reg_sel)
                  2'd0:    rd_data[2:0] = {ien_q[i], mode_q[i], en_q[i]};
                  2'd1:    rd_data[CNT_WIDTH-1:0] = load_q[i];
                  2'd2:    rd_data[CNT_WIDTH-1:0] = count_q[i];
                  default: rd_data[0] = flag_q[i];
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ready_q     <= 1'b0;
         rdata_q     <= '0;
         presc_q     <= '0;
         presc_cnt_q <= '0;
         en_q        <= '0;
         mode_q      <= '0;
         ien_q       <= '0;
         flag_q      <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            load_q[i]  <= '0;
            count_q[i] <= '0;
         end
      end else begin
         ready_q     <= accept;
         if (accept) begin
            rdata_q <= bus_we ? '0 : rd_data;
         end
         presc_q     <= presc_d;
         presc_cnt_q <= presc_cnt_d;
         en_q        <= en_d;
         mode_q      <= mode_d;
         ien_q       <= ien_d;
         flag_q      <= flag_d;
         for (int i = 0; i < NUM_CH; i++) begin
            load_q[i]  <= load_d[i];
            count_q[i] <= count_d[i];
         end
      end
   end

   assign bus_ready = ready_q;
   assign bus_rdata = rdata_q;
   assign irq       = flag_q & ien_q;
   assign irq_any   = |irq;

endmodule
